dm_port_arbiter: RTL and testbench

Two-port access controller in front of the single-port data memory (DM). It arbitrates between the pipeline MEM stage (CPU port) and a word-only device/DMA port. It latches each granted request and converts CPU `sb`/`sh`/`sw` stores into byte-lane enables and replicated write data. It also stalls the pipeline until its access has completed, and flags misaligned CPU accesses instead of performing them.

---
 rtl/dm_port_arbiter_if.sv | 45 ++++
 rtl/dm_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the device/DMA port, the data memory
// and the arbiter. The arbiter takes the slave view; the surrounding system
// (requesters plus memory) takes the master view.
interface dm_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_type;
    logic        cpu_stall;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rdata;

    logic        dev_req;
    logic        dev_we;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic        dev_ack;
    logic [31:0] dev_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_type,
        input  cpu_stall, cpu_done, cpu_err, cpu_rdata,
        output dev_req, dev_we, dev_addr, dev_wdata,
        input  dev_ack, dev_rdata,
        input  mem_addr, mem_wdata, mem_be, mem_we,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_type,
        output cpu_stall, cpu_done, cpu_err, cpu_rdata,
        input  dev_req, dev_we, dev_addr, dev_wdata,
        output dev_ack, dev_rdata,
        output mem_addr, mem_wdata, mem_be, mem_we,
        input  mem_rdata
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port access controller for the single-port data memory. Arbitrates the
// CPU MEM stage against a word-only device port (round robin on ties), latches
// the granted request, expands CPU sub-word stores into byte lanes and
// replicated data, and reports misaligned/illegal CPU accesses as errors.
module dm_port_arbiter #(
    parameter int unsigned ADDR_LSB_W = 12
) (
    input logic              clk,
    input logic              reset,
    dm_port_arbiter_if.slave bus
);

    // Keeps the word index bits forwarded to the memory; byte offset and
    // anything above the memory range are forced to zero.
    localparam logic [31:0] ADDR_MASK =
        32'((64'd1 << (ADDR_LSB_W + 2)) - 64'd1) & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    logic        own;          // 0 = CPU owns the access, 1 = device
    logic        last;         // port granted most recently
    logic        lat_we;
    logic        lat_err;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        cpu_done_q;
    logic        cpu_err_q;
    logic        dev_ack_q;
    logic [31:0] cpu_rdata_q;
    logic [31:0] dev_rdata_q;

    logic [1:0]  cpu_off;
    logic        cpu_bad;
    logic [3:0]  cpu_lanes;
    logic [31:0] cpu_repl;

    logic        grant_ok;
    logic        grant_dev;
    logic [31:0] nxt_addr;
    logic [31:0] nxt_wdata;
    logic [3:0]  nxt_be;
    logic        nxt_we;
    logic        nxt_err;

    // Decode the CPU request into lane enables, replicated data and error flag.
    always_comb begin
        cpu_off   = bus.cpu_addr[1:0];
        cpu_bad   = 1'b0;
        cpu_lanes = '0;
        cpu_repl  = bus.cpu_wdata;
        if (bus.cpu_we) begin
            case (bus.cpu_type)
                3'b000: begin
                    cpu_lanes = 4'b0001 << cpu_off;
                    cpu_repl  = {4{bus.cpu_wdata[7:0]}};
                end
                3'b001: begin
                    cpu_bad   = cpu_off[0];
                    cpu_lanes = cpu_off[1] ? 4'b1100 : 4'b0011;
                    cpu_repl  = {2{bus.cpu_wdata[15:0]}};
                end
                3'b011: begin
                    cpu_bad   = (cpu_off != 2'b00);
                    cpu_lanes = 4'b1111;
                end
                default: cpu_bad = 1'b1;
            endcase
        end else begin
            cpu_bad = (cpu_off != 2'b00);
        end
        if (cpu_bad) begin
            cpu_lanes = '0;
        end
    end

    // Choose the next owner: round robin on ties in IDLE, only the other port in RESP.
    always_comb begin
        grant_ok  = 1'b0;
        grant_dev = 1'b0;
        case (state)
            IDLE: begin
                grant_ok  = bus.cpu_req | bus.dev_req;
                grant_dev = (bus.cpu_req & bus.dev_req) ? ~last : bus.dev_req;
            end
            RESP: begin
                grant_dev = ~own;
                grant_ok  = own ? bus.cpu_req : bus.dev_req;
            end
            default: ;
        endcase
    end

    // Payload of the winning port as it will be latched at the grant edge.
    always_comb begin
        nxt_addr  = grant_dev ? (bus.dev_addr & ADDR_MASK) : (bus.cpu_addr & ADDR_MASK);
        nxt_wdata = grant_dev ? bus.dev_wdata : cpu_repl;
        nxt_be    = grant_dev ? {4{bus.dev_we}} : cpu_lanes;
        nxt_we    = grant_dev ? bus.dev_we : bus.cpu_we;
        nxt_err   = ~grant_dev & cpu_bad;
    end

    // Access sequencer: grant/latch, one memory cycle, then the completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            own         <= 1'b0;
            last        <= 1'b1;
            lat_we      <= 1'b0;
            lat_err     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            cpu_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
            dev_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dev_rdata_q <= '0;
        end else begin
            cpu_done_q <= 1'b0;
            cpu_err_q  <= 1'b0;
            dev_ack_q  <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (grant_ok) begin
                        own     <= grant_dev;
                        last    <= grant_dev;
                        lat_we  <= nxt_we;
                        lat_err <= nxt_err;
                        addr_q  <= nxt_addr;
                        wdata_q <= nxt_wdata;
                        be_q    <= nxt_be;
                        state   <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (own) begin
                        dev_rdata_q <= bus.mem_rdata;
                        dev_ack_q   <= 1'b1;
                    end else begin
                        cpu_rdata_q <= lat_err ? '0 : bus.mem_rdata;
                        cpu_done_q  <= 1'b1;
                        cpu_err_q   <= lat_err;
                    end
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_stall = bus.cpu_req & ~cpu_done_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dev_ack   = dev_ack_q;
    assign bus.dev_rdata = dev_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_we    = (state == BUSY) & lat_we & ~lat_err & ~reset;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a small word memory sits behind the arbiter, a
// timeline model predicts every completion and memory write, and directed
// scenarios add hand-computed literal expectations.
module tb_dm_port_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dm_port_arbiter_if bus ();

    dm_port_arbiter #(.ADDR_LSB_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Data memory behind the arbiter: combinational read, byte-lane write at the edge.
    logic [31:0] dm [0:4095];
    assign bus.mem_rdata = dm[bus.mem_addr[13:2]];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_be[b]) dm[bus.mem_addr[13:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- timeline model ----------------
    typedef struct {
        int          acc;
        int          fin;
        bit          dev;
        bit          we;
        bit          err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [3:0]  be;
    } txn_t;

    txn_t        q[$];
    logic [31:0] mm [int];
    int          cyc     = 0;
    int          free_at = 0;
    int          blk_at  = -1;
    bit          blk_dev = 1'b0;
    bit          m_last  = 1'b1;

    int          wr_cnt = 0;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_be;
    int          log_port[$];
    int          log_cyc[$];

    function automatic txn_t mk_cpu(logic we, logic [31:0] a, logic [31:0] d, logic [2:0] ty);
        txn_t t;
        int   off;
        off     = int'(a % 4);
        t.acc   = 0;
        t.fin   = 0;
        t.dev   = 1'b0;
        t.we    = we;
        t.rd    = '0;
        t.addr  = (a % 32'h4000) / 4 * 4;
        if (!we)            t.err = (off != 0);
        else if (ty == 3'd0) t.err = 1'b0;
        else if (ty == 3'd1) t.err = (off % 2 != 0);
        else if (ty == 3'd3) t.err = (off != 0);
        else                t.err = 1'b1;
        if (ty == 3'd0)      t.wdata = (d % 256) * 32'h0101_0101;
        else if (ty == 3'd1) t.wdata = (d % 65536) * 32'h0001_0001;
        else                t.wdata = d;
        if (!we || t.err)    t.be = 4'h0;
        else if (ty == 3'd0) t.be = 4'(1 << off);
        else if (ty == 3'd1) t.be = (off >= 2) ? 4'hC : 4'h3;
        else                t.be = 4'hF;
        return t;
    endfunction

    function automatic txn_t mk_dev(logic we, logic [31:0] a, logic [31:0] d);
        txn_t t;
        t.acc   = 0;
        t.fin   = 0;
        t.dev   = 1'b1;
        t.we    = we;
        t.err   = 1'b0;
        t.rd    = '0;
        t.addr  = (a % 32'h4000) / 4 * 4;
        t.wdata = d;
        t.be    = we ? 4'hF : 4'h0;
        return t;
    endfunction

    // Compare every cycle against the model, then let the model decide this cycle's grant.
    always @(negedge clk) begin
        logic        e_we, e_cd, e_ce, e_da;
        logic [31:0] e_cr, e_dr;
        txn_t        t;
        bit          ec, ed, wd;
        int          k;
        e_we = 1'b0; e_cd = 1'b0; e_ce = 1'b0; e_da = 1'b0;
        e_cr = '0;   e_dr = '0;
        for (int i = 0; i < q.size(); i++) begin
            t = q[i];
            if (t.acc == cyc) begin
                k    = int'(t.addr / 4);
                t.rd = t.err ? 32'h0 : (mm.exists(k) ? mm[k] : 32'h0);
                e_we = t.we && !t.err && !reset;
                chk("mem_addr", bus.mem_addr, t.addr);
                chk("mem_be", 32'(bus.mem_be), 32'(t.be));
                if (e_we) begin
                    chk("mem_wdata", bus.mem_wdata, t.wdata);
                    if (!mm.exists(k)) mm[k] = 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (t.be[b]) mm[k][8*b +: 8] = t.wdata[8*b +: 8];
                    end
                end
                q[i] = t;
            end
            if (t.fin == cyc) begin
                if (t.dev) begin
                    e_da = 1'b1; e_dr = t.rd;
                end else begin
                    e_cd = 1'b1; e_ce = t.err; e_cr = t.rd;
                end
            end
        end
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("cpu_done", 32'(bus.cpu_done), 32'(e_cd));
        chk("cpu_err", 32'(bus.cpu_err), 32'(e_ce));
        chk("dev_ack", 32'(bus.dev_ack), 32'(e_da));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req & ~e_cd));
        if (e_cd) chk("cpu_rdata", bus.cpu_rdata, e_cr);
        if (e_da) chk("dev_rdata", bus.dev_rdata, e_dr);

        if (bus.mem_we) begin
            wr_cnt++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata; wr_be = bus.mem_be;
        end
        if (bus.cpu_done) begin log_port.push_back(0); log_cyc.push_back(cyc); end
        if (bus.dev_ack)  begin log_port.push_back(1); log_cyc.push_back(cyc); end

        while (q.size() > 0 && q[0].fin <= cyc) void'(q.pop_front());

        if (reset) begin
            q.delete();
            free_at = cyc + 1;
            blk_at  = -1;
            m_last  = 1'b1;
        end else begin
            ec = bus.cpu_req && cyc >= free_at && !(cyc == blk_at && !blk_dev);
            ed = bus.dev_req && cyc >= free_at && !(cyc == blk_at && blk_dev);
            if (ec || ed) begin
                wd = (ec && ed) ? !m_last : ed;
                t = wd ? mk_dev(bus.dev_we, bus.dev_addr, bus.dev_wdata)
                       : mk_cpu(bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, bus.cpu_type);
                t.acc = cyc + 1;
                t.fin = cyc + 2;
                q.push_back(t);
                free_at = cyc + 2;
                blk_at  = cyc + 2;
                blk_dev = wd;
                m_last  = wd;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic cpu_go(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] ty, output logic [31:0] rd, output logic er,
                          output int lat, output logic [2:0] stl);
        bit got;
        got = 1'b0; rd = '0; er = 1'b0; lat = 0; stl = '0;
        bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_type = ty;
        bus.cpu_req = 1'b1;
        while (!got && lat < 20) begin
            @(negedge clk);
            if (lat < 3) stl[lat] = bus.cpu_stall;
            lat++;
            if (bus.cpu_done) begin
                got = 1'b1; rd = bus.cpu_rdata; er = bus.cpu_err;
            end
        end
        chk("cpu_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic dev_go(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
        bit got;
        int n;
        got = 1'b0; rd = '0; n = 0;
        bus.dev_we = we; bus.dev_addr = a; bus.dev_wdata = d;
        bus.dev_req = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.dev_ack) begin
                got = 1'b1; rd = bus.dev_rdata;
            end
        end
        chk("dev_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.dev_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd_c, rd_d, rd2;
        logic        er;
        logic [2:0]  stl;
        int          lat, w0;

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cpu_type = 3'b011;
        bus.dev_req = 1'b0; bus.dev_we = 1'b0; bus.dev_addr = '0; bus.dev_wdata = '0;
        for (int i = 0; i < 4096; i++) dm[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_done", 32'(bus.cpu_done), 32'd0);
        chk("rst_dev_ack", 32'(bus.dev_ack), 32'd0);
        chk("rst_cpu_err", 32'(bus.cpu_err), 32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_dev_rdata", bus.dev_rdata, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        reset = 1'b0;

        // Lone CPU sw, then read back; load latency and stall profile.
        w0 = wr_cnt;
        cpu_go(1'b1, 32'h10, 32'h1234_5678, 3'b011, rd, er, lat, stl);
        chk("sw_latency", 32'(lat), 32'd3);
        chk("sw_wr_count", 32'(wr_cnt - w0), 32'd1);
        chk("sw_be", 32'(wr_be), 32'hF);
        chk("sw_addr", wr_addr, 32'h10);
        chk("sw_data", wr_data, 32'h1234_5678);
        cpu_go(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat, stl);
        chk("lw_data", rd, 32'h1234_5678);
        chk("lw_stall", 32'(stl), 32'h3);
        chk("lw_latency", 32'(lat), 32'd3);

        // Sub-word stores.
        cpu_go(1'b1, 32'h13, 32'h0000_00AB, 3'b000, rd, er, lat, stl);
        chk("sb_be", 32'(wr_be), 32'h8);
        chk("sb_data", wr_data, 32'hABAB_ABAB);
        cpu_go(1'b1, 32'h12, 32'h0000_BEEF, 3'b001, rd, er, lat, stl);
        chk("sh_be", 32'(wr_be), 32'hC);
        chk("sh_data", wr_data, 32'hBEEF_BEEF);
        chk("sh_err", 32'(er), 32'd0);
        cpu_go(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat, stl);
        chk("merged_word", rd, 32'hBEEF_5678);

        // Misaligned / illegal accesses.
        w0 = wr_cnt;
        cpu_go(1'b1, 32'h02, 32'hDEAD_BEEF, 3'b011, rd, er, lat, stl);
        chk("sw_mis_err", 32'(er), 32'd1);
        chk("sw_mis_rdata", rd, 32'd0);
        cpu_go(1'b1, 32'h11, 32'h0000_1111, 3'b001, rd, er, lat, stl);
        chk("sh_mis_err", 32'(er), 32'd1);
        cpu_go(1'b1, 32'h10, 32'h0000_2222, 3'b010, rd, er, lat, stl);
        chk("bad_type_err", 32'(er), 32'd1);
        cpu_go(1'b0, 32'h13, 32'h0, 3'b011, rd, er, lat, stl);
        chk("lw_mis_err", 32'(er), 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        chk("err_no_write", 32'(wr_cnt - w0), 32'd0);
        cpu_go(1'b0, 32'h00, 32'h0, 3'b011, rd, er, lat, stl);
        chk("word0_intact", rd, 32'd0);

        // Simultaneous requests right after reset: CPU, DEV, CPU, DEV.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        log_port.delete(); log_cyc.delete();
        fork
            begin
                cpu_go(1'b1, 32'h100, 32'hAAAA_0001, 3'b011, rd2, er, lat, stl);
                cpu_go(1'b0, 32'h100, 32'h0, 3'b011, rd_c, er, lat, stl);
            end
            begin
                dev_go(1'b1, 32'h200, 32'hBBBB_0002, rd2);
                dev_go(1'b0, 32'h200, 32'h0, rd_d);
            end
        join
        chk("tie_count", 32'(log_port.size()), 32'd4);
        if (log_port.size() == 4) begin
            chk("tie_g0", 32'(log_port[0]), 32'd0);
            chk("tie_g1", 32'(log_port[1]), 32'd1);
            chk("tie_g2", 32'(log_port[2]), 32'd0);
            chk("tie_g3", 32'(log_port[3]), 32'd1);
            chk("tie_gap1", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
            chk("tie_gap2", 32'(log_cyc[2] - log_cyc[1]), 32'd2);
            chk("tie_gap3", 32'(log_cyc[3] - log_cyc[2]), 32'd2);
        end
        chk("tie_cpu_rd", rd_c, 32'hAAAA_0001);
        chk("tie_dev_rd", rd_d, 32'hBBBB_0002);

        // Reset during a device write's BUSY cycle drops the write.
        dev_go(1'b1, 32'h40, 32'h1111_2222, rd);
        log_port.delete(); log_cyc.delete();
        w0 = wr_cnt;
        bus.dev_we = 1'b1; bus.dev_addr = 32'h40; bus.dev_wdata = 32'hCAFE_F00D;
        bus.dev_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.dev_req = 1'b0;
        @(negedge clk);
        chk("rstbusy_mem_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk); #1;
        chk("rstbusy_dev_ack", 32'(bus.dev_ack), 32'd0);
        chk("rstbusy_cpu_done", 32'(bus.cpu_done), 32'd0);
        chk("rstbusy_cpu_err", 32'(bus.cpu_err), 32'd0);
        chk("rstbusy_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rstbusy_mem_addr", bus.mem_addr, 32'd0);
        chk("rstbusy_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rstbusy_dev_rdata", bus.dev_rdata, 32'd0);
        chk("rstbusy_cpu_rdata", bus.cpu_rdata, 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstbusy_no_ack", 32'(log_port.size()), 32'd0);
        chk("rstbusy_no_write", 32'(wr_cnt - w0), 32'd0);
        dev_go(1'b0, 32'h1234_0042, 32'h0, rd);
        chk("rstbusy_old_word", rd, 32'h1111_2222);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
